// File: rtl/first_nios2_system_cpu_mul_seq_pkg.sv
// Shared types and sizes for the 32x32 multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package first_nios2_system_cpu_mul_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = 8;
    localparam int IDX_W   = 3;

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/first_nios2_system_cpu_mul_seq_if.sv
// M-stage request/response and multiplier-cell signals of the multiply sequencer.
// Latency: n/a (wiring only).
// Backpressure: M_mul_busy blocks new starts; the cell has no flow control.
interface first_nios2_system_cpu_mul_seq_if;
    import first_nios2_system_cpu_mul_seq_pkg::*;

    logic [DATA_W-1:0] M_mul_src1;
    logic [DATA_W-1:0] M_mul_src2;
    logic              M_mul_start;
    logic              M_mul_busy;
    logic              M_mul_done;
    logic [DATA_W-1:0] M_mul_result;
    logic [DATA_W-1:0] M_mul_cell_src1;
    logic [NIB_W-1:0]  M_mul_cell_src2;
    logic [DATA_W-1:0] M_mul_cell_result;

    // M stage plus multiplier cell, as seen from outside the sequencer
    modport master (
        output M_mul_src1, M_mul_src2, M_mul_start, M_mul_cell_result,
        input  M_mul_busy, M_mul_done, M_mul_result, M_mul_cell_src1, M_mul_cell_src2
    );

    modport slave (
        input  M_mul_src1, M_mul_src2, M_mul_start, M_mul_cell_result,
        output M_mul_busy, M_mul_done, M_mul_result, M_mul_cell_src1, M_mul_cell_src2
    );

endinterface

// File: rtl/first_nios2_system_cpu_mul_seq_acc.sv
// Shift-accumulate of 32x4 partial products into the low product word.
// Latency: acc updates on the edge after acc_en; acc_sum is combinational.
// Backpressure: none; acc_clr has priority over acc_en.
module first_nios2_system_cpu_mul_seq_acc
    import first_nios2_system_cpu_mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] cell_result,
    input  logic [IDX_W-1:0]  idx,
    input  logic              acc_en,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] acc_sum
);

    // Shift by 4*idx; bits pushed past bit 31 belong to the discarded high word
    assign acc_sum = acc + (cell_result << {idx, 2'b00});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/first_nios2_system_cpu_mul_seq.sv
// Nibble-serial 32x32 multiply sequencer feeding a registered 32x4 cell; low word result.
// Latency: 10 cycles start-to-done, or 3..10 with MUL_SEQ_EARLY_EXIT_EN defined.
// Backpressure: M_mul_busy high in RUN/DRAIN; starts while busy are dropped.
module first_nios2_system_cpu_mul_seq
    import first_nios2_system_cpu_mul_seq_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset_n,
    first_nios2_system_cpu_mul_seq_if.slave  mul
);

    state_e            state;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  k_nxt;
    logic [IDX_W-1:0]  ridx;
    logic [DATA_W-1:0] src2_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_sum;
    logic              start_ok;
    logic              acc_en;
    logic              last_nib;

    assign k_nxt    = k + 1'b1;
    assign start_ok = mul.M_mul_start && ((state == IDLE) || (state == DONE));
    // The cell output lags issue by one cycle, so nothing retires in the first RUN cycle
    assign acc_en   = ((state == RUN) && (k != '0)) || (state == DRAIN);

`ifdef MUL_SEQ_EARLY_EXIT_EN
    logic [5:0] rem_sh;
    assign rem_sh   = {1'b0, k, 2'b00} + 6'd4;
    assign last_nib = (k == LAST_K) || ((src2_q >> rem_sh) == '0);
`else
    assign last_nib = (k == LAST_K);
`endif

    first_nios2_system_cpu_mul_seq_acc u_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .cell_result (mul.M_mul_cell_result),
        .idx         (ridx),
        .acc_en      (acc_en),
        .acc_clr     (start_ok),
        .acc         (acc),
        .acc_sum     (acc_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            k                   <= '0;
            ridx                <= '0;
            src2_q              <= '0;
            mul.M_mul_busy      <= 1'b0;
            mul.M_mul_done      <= 1'b0;
            mul.M_mul_result    <= '0;
            mul.M_mul_cell_src1 <= '0;
            mul.M_mul_cell_src2 <= '0;
        end else begin
            mul.M_mul_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state               <= RUN;
                        k                   <= '0;
                        src2_q              <= mul.M_mul_src2;
                        mul.M_mul_busy      <= 1'b1;
                        mul.M_mul_cell_src1 <= mul.M_mul_src1;
                        mul.M_mul_cell_src2 <= mul.M_mul_src2[NIB_W-1:0];
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    ridx <= k;
                    k    <= k_nxt;
                    if (last_nib) begin
                        state               <= DRAIN;
                        mul.M_mul_cell_src1 <= '0;
                        mul.M_mul_cell_src2 <= '0;
                    end else begin
                        mul.M_mul_cell_src2 <= src2_q[{k_nxt, 2'b00} +: NIB_W];
                    end
                end
                DRAIN: begin
                    state            <= DONE;
                    mul.M_mul_busy   <= 1'b0;
                    mul.M_mul_done   <= 1'b1;
                    mul.M_mul_result <= acc_sum;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_first_nios2_system_cpu_mul_seq.sv
// Bench for the multiply sequencer with a registered 32x4 cell model.
module tb_first_nios2_system_cpu_mul_seq;
    import first_nios2_system_cpu_mul_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    first_nios2_system_cpu_mul_seq_if mul_if();

    first_nios2_system_cpu_mul_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mul     (mul_if)
    );

    // Multiplier cell: one register stage, cleared by the shared reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mul_if.M_mul_cell_result <= '0;
        else          mul_if.M_mul_cell_result <= mul_if.M_mul_cell_src1 * {28'd0, mul_if.M_mul_cell_src2};
    end

    typedef struct {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] s2);
        int h;
        h = 0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        for (int i = 0; i < 8; i++) if (s2[4*i +: 4] != 4'd0) h = i;
        return 3 + h;
`else
        h = (s2 == 32'd0) ? 0 : 0;
        return 10 + h;
`endif
    endfunction

    // Called just after an edge; the start is sampled on the following edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        mul_if.M_mul_src1  = a;
        mul_if.M_mul_src2  = b;
        mul_if.M_mul_start = 1'b1;
        @(posedge clk); #1;
        mul_if.M_mul_start = 1'b0;
    endtask

    // Starts in cycle 1; optionally pulses a stray start (5*5) in cycle inj_cyc.
    task automatic wait_done(input int inj_cyc, output logic [31:0] res, output int lat, output bit busy_ok);
        int cyc;
        cyc = 1;
        busy_ok = 1'b1;
        lat = 0;
        res = '0;
        while (cyc <= 20) begin
            if (cyc == inj_cyc) begin
                mul_if.M_mul_start = 1'b1;
                mul_if.M_mul_src1  = 32'd5;
                mul_if.M_mul_src2  = 32'd5;
            end else begin
                mul_if.M_mul_start = 1'b0;
            end
            if (mul_if.M_mul_done) begin
                lat = cyc;
                res = mul_if.M_mul_result;
                if (mul_if.M_mul_busy) busy_ok = 1'b0;
                break;
            end
            if (!mul_if.M_mul_busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        mul_if.M_mul_start = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        bit          bok;
        issue(a, b);
        wait_done(0, res, lat, bok);
        check({name, " result"}, res, exp);
        check({name, " latency"}, lat, exp_lat(b));
        check({name, " busy"}, {31'd0, bok}, 32'd1);
        @(posedge clk); #1;
        check({name, " done width"}, {31'd0, mul_if.M_mul_done}, 32'd0);
        check({name, " held"}, mul_if.M_mul_result, exp);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] r1, r2, a, b;
        int          l1, l2, dcnt;
        bit          b1, b2;

        vecs[0] = '{32'h12345678, 32'h00000010, 32'h23456780};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{32'h00010000, 32'h00010000, 32'h00000000};
        vecs[3] = '{32'h00000007, 32'h00000003, 32'h00000015};
        vecs[4] = '{32'h11111111, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'h00000001, 32'h80000000, 32'h80000000};
        vecs[6] = '{32'h0000ABCD, 32'h00000100, 32'h00ABCD00};
        vecs[7] = '{32'h00000003, 32'h00050000, 32'h000F0000};

        mul_if.M_mul_src1  = '0;
        mul_if.M_mul_src2  = '0;
        mul_if.M_mul_start = 1'b0;

        #2;
        check("rst busy", {31'd0, mul_if.M_mul_busy}, 32'd0);
        check("rst done", {31'd0, mul_if.M_mul_done}, 32'd0);
        check("rst result", mul_if.M_mul_result, 32'd0);
        check("rst cell_src1", mul_if.M_mul_cell_src1, 32'd0);
        check("rst cell_src2", {28'd0, mul_if.M_mul_cell_src2}, 32'd0);
        #20 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_one($sformatf("vec%0d", i), vecs[i].src1, vecs[i].src2, vecs[i].exp);

        // Stray start in cycle 4 must not disturb or re-latch the running op
        issue(32'h12345678, 32'h10000010);
        wait_done(4, r1, l1, b1);
        check("busy-start result", r1, 32'hA3456780);
        check("busy-start latency", l1, exp_lat(32'h10000010));
        check("busy-start busy", {31'd0, b1}, 32'd1);
        @(posedge clk); #1;
        check("busy-start no requeue", {31'd0, mul_if.M_mul_busy}, 32'd0);

        // Start accepted in the DONE cycle: next op starts with no gap
        issue(32'h0000ABCD, 32'h00000100);
        wait_done(0, r1, l1, b1);
        check("b2b first result", r1, 32'h00ABCD00);
        check("b2b first latency", l1, exp_lat(32'h00000100));
        issue(32'h01010101, 32'h00000101);
        wait_done(0, r2, l2, b2);
        check("b2b second result", r2, 32'h02020201);
        check("b2b second latency", l2, exp_lat(32'h00000101));
        check("b2b second busy", {31'd0, b2}, 32'd1);

        // Reset in cycle 5 aborts with no done pulse afterwards
        issue(32'hFFFFFFFF, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        check("abort busy", {31'd0, mul_if.M_mul_busy}, 32'd0);
        check("abort done", {31'd0, mul_if.M_mul_done}, 32'd0);
        check("abort result", mul_if.M_mul_result, 32'd0);
        check("abort cell_src1", mul_if.M_mul_cell_src1, 32'd0);
        check("abort cell_src2", {28'd0, mul_if.M_mul_cell_src2}, 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (mul_if.M_mul_done || mul_if.M_mul_busy) dcnt++;
        end
        check("abort no done", dcnt, 32'd0);
        run_one("post-reset", 32'h0000ABCD, 32'h00000100, 32'h00ABCD00);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            b = b >> (4 * $urandom_range(0, 8));
            run_one($sformatf("rand%0d", i), a, b, a * b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule
